// File: rtl/pe_row_scheduler_if.sv
// Request/response bundle between the row scheduler and the Q/K/V fetch
// units, the PE output strobe and the OSRAM write port.
interface pe_row_scheduler_if #(
    parameter int ADDR_W = 12
);
    logic              q_req_vld;
    logic              q_req_rdy;
    logic [ADDR_W-1:0] q_req_addr;
    logic              kv_req_vld;
    logic              kv_req_rdy;
    logic [ADDR_W-1:0] kv_req_addr;
    logic              kv_req_last;
    logic              pe_out_vld;
    logic              o_sram_rdy;
    logic              o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;

    modport master (
        output q_req_vld, q_req_addr,
        input  q_req_rdy,
        output kv_req_vld, kv_req_addr, kv_req_last,
        input  kv_req_rdy,
        input  pe_out_vld, o_sram_rdy,
        output o_wr_en, o_wr_addr
    );

    modport slave (
        input  q_req_vld, q_req_addr,
        output q_req_rdy,
        input  kv_req_vld, kv_req_addr, kv_req_last,
        output kv_req_rdy,
        output pe_out_vld, o_sram_rdy,
        input  o_wr_en, o_wr_addr
    );
endinterface

// File: rtl/pe_row_scheduler.sv
// Sequences one attention job through a single PE, one query row at a time:
// Q fetch, NUM_KV K/V fetches, then wait for the PE result and write it to OSRAM.
module pe_row_scheduler #(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     cfg_num_q,
    input  logic [CNT_W-1:0]     cfg_num_kv,
    input  logic [ADDR_W-1:0]    cfg_q_base,
    input  logic [ADDR_W-1:0]    cfg_kv_base,
    input  logic [ADDR_W-1:0]    cfg_o_base,
    pe_row_scheduler_if.master   bus,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_Q,
        STREAM,
        DRAIN,
        FIN
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]  num_q;
    logic [CNT_W-1:0]  num_kv;
    logic [ADDR_W-1:0] q_base;
    logic [ADDR_W-1:0] kv_base;
    logic [ADDR_W-1:0] o_base;
    logic [CNT_W-1:0]  row;
    logic [CNT_W-1:0]  kv;

    logic kv_last;
    logic row_last;
    logic kv_fire;
    logic wr_fire;

    assign kv_last  = (kv == num_kv - CNT_W'(1));
    assign row_last = (row == num_q - CNT_W'(1));

    // Addresses are sums of latched registers only, so they hold steady while a request stalls
    always_comb begin
        bus.q_req_addr  = q_base  + ADDR_W'(row);
        bus.kv_req_addr = kv_base + ADDR_W'(kv);
        bus.o_wr_addr   = o_base  + ADDR_W'(row);
        bus.kv_req_last = (state == STREAM) && kv_last;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded outputs; ready inputs only steer the next state, never a valid
    always_comb begin
        state_nxt      = state;
        bus.q_req_vld  = 1'b0;
        bus.kv_req_vld = 1'b0;
        bus.o_wr_en    = 1'b0;
        busy           = 1'b1;
        done           = 1'b0;
        kv_fire        = 1'b0;
        wr_fire        = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (cfg_num_q == '0 || cfg_num_kv == '0) begin
                        state_nxt = FIN;
                    end else begin
                        state_nxt = LOAD_Q;
                    end
                end
            end
            LOAD_Q: begin
                bus.q_req_vld = 1'b1;
                if (bus.q_req_rdy) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                bus.kv_req_vld = 1'b1;
                kv_fire        = bus.kv_req_rdy;
                if (kv_fire && kv_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                wr_fire     = bus.pe_out_vld & bus.o_sram_rdy;
                bus.o_wr_en = wr_fire;
                if (wr_fire) begin
                    state_nxt = row_last ? FIN : LOAD_Q;
                end
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Job configuration latch and row / K/V counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_q   <= '0;
            num_kv  <= '0;
            q_base  <= '0;
            kv_base <= '0;
            o_base  <= '0;
            row     <= '0;
            kv      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        num_q   <= cfg_num_q;
                        num_kv  <= cfg_num_kv;
                        q_base  <= cfg_q_base;
                        kv_base <= cfg_kv_base;
                        o_base  <= cfg_o_base;
                        row     <= '0;
                        kv      <= '0;
                    end
                end
                STREAM: begin
                    if (kv_fire) begin
                        kv <= kv_last ? '0 : kv + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    if (wr_fire && !row_last) begin
                        row <= row + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_row_scheduler.sv
// Directed bench for pe_row_scheduler: a table of jobs with hand-computed
// request/write counts and busy lengths, plus hand-written sequences for
// K/V back-pressure, OSRAM stall with an ignored start, and async reset.
module tb_pe_row_scheduler;

    localparam int ADDR_W = 12;
    localparam int CNT_W  = 10;
    localparam int PE_LAT = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  cfg_num_q = '0;
    logic [CNT_W-1:0]  cfg_num_kv = '0;
    logic [ADDR_W-1:0] cfg_q_base = '0;
    logic [ADDR_W-1:0] cfg_kv_base = '0;
    logic [ADDR_W-1:0] cfg_o_base = '0;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    pe_row_scheduler_if #(.ADDR_W(ADDR_W)) bus();

    pe_row_scheduler #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_num_q  (cfg_num_q),
        .cfg_num_kv (cfg_num_kv),
        .cfg_q_base (cfg_q_base),
        .cfg_kv_base(cfg_kv_base),
        .cfg_o_base (cfg_o_base),
        .bus        (bus),
        .busy       (busy),
        .done       (done)
    );

    int checks = 0;
    int errors = 0;

    // bench controls (written by the main sequence only)
    logic kv_toggle = 1'b0;
    logic o_block = 1'b0;
    logic pe_spurious = 1'b0;
    int   clr_epoch = 0;

    // monitor log (written by the monitor only)
    logic [ADDR_W-1:0] q_log[$];
    logic [ADDR_W-1:0] kv_log[$];
    logic              last_log[$];
    logic [ADDR_W-1:0] wr_log[$];
    int   cyc = 0, busy_cnt = 0, done_cnt = 0, done_cyc = -1, wr_cyc = -1;
    int   kv_stall_cnt = 0, hold_viol = 0, qual_viol = 0, seen_epoch = 0;
    logic kv_last_seen = 1'b0, wr_seen = 1'b0, prev_kv_stall = 1'b0;
    logic [ADDR_W-1:0] prev_kv_addr = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] out_vec();
        return {22'b0, bus.q_req_vld, bus.q_req_addr, bus.kv_req_vld, bus.kv_req_addr,
                bus.kv_req_last, bus.o_wr_en, bus.o_wr_addr, busy, done};
    endfunction

    // Monitor: at the falling edge the values about to be sampled by the next rising edge are stable
    initial begin
        forever begin
            @(negedge clk);
            if (clr_epoch != seen_epoch) begin
                seen_epoch = clr_epoch;
                q_log.delete(); kv_log.delete(); last_log.delete(); wr_log.delete();
                busy_cnt = 0; done_cnt = 0; done_cyc = -1; wr_cyc = -1;
                kv_stall_cnt = 0; hold_viol = 0; qual_viol = 0;
            end
            cyc++;
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (bus.q_req_vld && bus.q_req_rdy) q_log.push_back(bus.q_req_addr);
            if (bus.kv_req_vld && bus.kv_req_rdy) begin
                kv_log.push_back(bus.kv_req_addr);
                last_log.push_back(bus.kv_req_last);
            end
            if (bus.o_wr_en) begin wr_log.push_back(bus.o_wr_addr); wr_cyc = cyc; end
            if (bus.o_wr_en && !(bus.pe_out_vld && bus.o_sram_rdy)) qual_viol++;
            if (prev_kv_stall && !rst &&
                (!bus.kv_req_vld || bus.kv_req_addr != prev_kv_addr)) hold_viol++;
            if (bus.kv_req_vld && !bus.kv_req_rdy) kv_stall_cnt++;
            prev_kv_stall = bus.kv_req_vld && !bus.kv_req_rdy;
            prev_kv_addr  = bus.kv_req_addr;
            kv_last_seen  = bus.kv_req_vld && bus.kv_req_rdy && bus.kv_req_last;
            wr_seen       = bus.o_wr_en;
        end
    end

    // Fetch-unit / PE / OSRAM responder: PE result rises PE_LAT cycles after the last K/V handshake
    initial begin
        int   pe_cnt;
        logic pe_real;
        pe_cnt  = 0;
        pe_real = 1'b0;
        bus.q_req_rdy  = 1'b1;
        bus.kv_req_rdy = 1'b1;
        bus.o_sram_rdy = 1'b1;
        bus.pe_out_vld = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                pe_cnt  = 0;
                pe_real = 1'b0;
            end else begin
                if (wr_seen) pe_real = 1'b0;
                if (pe_cnt > 0) begin
                    pe_cnt--;
                    if (pe_cnt == 0) pe_real = 1'b1;
                end
                if (kv_last_seen) pe_cnt = PE_LAT;
            end
            bus.kv_req_rdy = kv_toggle ? ~bus.kv_req_rdy : 1'b1;
            bus.o_sram_rdy = ~o_block;
            bus.pe_out_vld = pe_real | pe_spurious;
        end
    end

    task automatic start_job(input int nq, input int nkv, input logic [ADDR_W-1:0] qb,
                             input logic [ADDR_W-1:0] kvb, input logic [ADDR_W-1:0] ob);
        @(posedge clk);
        #2;
        clr_epoch++;
        cfg_num_q   = CNT_W'(nq);
        cfg_num_kv  = CNT_W'(nkv);
        cfg_q_base  = qb;
        cfg_kv_base = kvb;
        cfg_o_base  = ob;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done_cnt == 0 && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, done_cnt != 0, 1);
        repeat (3) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check_job(input int nq, input int nkv, input logic [ADDR_W-1:0] qb,
                             input logic [ADDR_W-1:0] kvb, input logic [ADDR_W-1:0] ob,
                             input int exp_q, input int exp_kv, input int exp_wr);
        logic [ADDR_W-1:0] e;
        chk("q_count", q_log.size(), exp_q);
        chk("kv_count", kv_log.size(), exp_kv);
        chk("wr_count", wr_log.size(), exp_wr);
        chk("done_count", done_cnt, 1);
        chk("idle_after", busy, 0);
        chk("kv_hold", hold_viol, 0);
        chk("wr_qualify", qual_viol, 0);
        foreach (q_log[r]) begin
            e = qb + ADDR_W'(r);
            chk("q_addr", q_log[r], e);
        end
        foreach (kv_log[i]) begin
            e = kvb + ADDR_W'(i % nkv);
            chk("kv_addr", kv_log[i], e);
            chk("kv_last", last_log[i], (i % nkv) == nkv - 1);
        end
        foreach (wr_log[r]) begin
            e = ob + ADDR_W'(r);
            chk("wr_addr", wr_log[r], e);
        end
        if (exp_wr > 0) chk("done_after_wr", done_cyc - wr_cyc, 1);
        if (nq == 0) chk("zero_q_busy", busy_cnt, 1);
    endtask

    typedef struct {
        int                nq;
        int                nkv;
        logic [ADDR_W-1:0] qb;
        logic [ADDR_W-1:0] kvb;
        logic [ADDR_W-1:0] ob;
        int                exp_busy;
        int                exp_q;
        int                exp_kv;
        int                exp_wr;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int   n;
        // busy per row = 1 (Q) + nkv + (PE_LAT + 1) DRAIN cycles; plus one FIN cycle per job
        vecs[0] = '{1, 4, 12'h010, 12'h020, 12'h030,  9, 1, 4, 1};
        vecs[1] = '{3, 2, 12'h100, 12'h200, 12'h300, 19, 3, 6, 3};
        vecs[2] = '{2, 0, 12'h111, 12'h222, 12'h333,  1, 0, 0, 0};
        vecs[3] = '{0, 3, 12'h111, 12'h222, 12'h333,  1, 0, 0, 0};
        vecs[4] = '{2, 1, 12'h7F0, 12'h005, 12'hFFF, 11, 2, 2, 2};
        vecs[5] = '{1, 3, 12'hFFF, 12'hFFE, 12'h000,  8, 1, 3, 1};

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs", out_vec(), 64'h0);
        rst = 1'b0;

        // pe_out_vld while idle must not write
        pe_spurious = 1'b1;
        repeat (4) begin
            @(negedge clk);
            #1;
        end
        chk("spurious_wr_en", bus.o_wr_en, 0);
        chk("spurious_wr_log", wr_log.size(), 0);
        pe_spurious = 1'b0;

        foreach (vecs[v]) begin
            start_job(vecs[v].nq, vecs[v].nkv, vecs[v].qb, vecs[v].kvb, vecs[v].ob);
            wait_done("table_done");
            chk("table_busy", busy_cnt, vecs[v].exp_busy);
            check_job(vecs[v].nq, vecs[v].nkv, vecs[v].qb, vecs[v].kvb, vecs[v].ob,
                      vecs[v].exp_q, vecs[v].exp_kv, vecs[v].exp_wr);
        end

        // K/V ready toggling every cycle
        kv_toggle = 1'b1;
        start_job(1, 5, 12'h050, 12'h060, 12'h070);
        wait_done("toggle_done");
        check_job(1, 5, 12'h050, 12'h060, 12'h070, 1, 5, 1);
        chk("toggle_stalled", kv_stall_cnt >= 4, 1);
        kv_toggle = 1'b0;

        // OSRAM stall with pe_out_vld high, start pulsed during the stall
        o_block = 1'b1;
        start_job(1, 2, 12'h0A0, 12'h0B0, 12'h0C0);
        n = 0;
        while (!bus.pe_out_vld && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain_reach", bus.pe_out_vld, 1);
        for (int i = 0; i < 6; i++) begin
            chk("stall_no_wr", bus.o_wr_en, 0);
            chk("stall_busy", busy, 1);
            chk("stall_addr", bus.o_wr_addr, 12'h0C0);
            if (i == 1) begin
                cfg_num_q  = CNT_W'(3);
                cfg_q_base = 12'h555;
                start = 1'b1;
            end
            if (i == 2) start = 1'b0;
            @(negedge clk);
            #1;
        end
        start = 1'b0;
        o_block = 1'b0;
        n = 0;
        while (!bus.o_sram_rdy && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("stall_release_wr", bus.o_wr_en, 1);
        chk("stall_release_addr", bus.o_wr_addr, 12'h0C0);
        wait_done("stall_done");
        check_job(1, 2, 12'h0A0, 12'h0B0, 12'h0C0, 1, 2, 1);
        repeat (5) begin
            @(negedge clk);
            #1;
        end
        chk("ignored_start_q", q_log.size(), 1);
        chk("ignored_start_busy", busy, 0);

        // async reset mid-STREAM with a wrapping K/V base
        start_job(2, 4, 12'h1F0, 12'hFFE, 12'h0D0);
        n = 0;
        while (kv_log.size() < 3 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("wrap_kv_count", kv_log.size(), 3);
        if (kv_log.size() == 3) begin
            chk("wrap_kv0", kv_log[0], 12'hFFE);
            chk("wrap_kv1", kv_log[1], 12'hFFF);
            chk("wrap_kv2", kv_log[2], 12'h000);
        end
        chk("pre_rst_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_outputs", out_vec(), 64'h0);
        @(negedge clk);
        #1;
        chk("rst_held_outputs", out_vec(), 64'h0);
        chk("rst_no_done", done_cnt, 0);
        rst = 1'b0;

        start_job(1, 2, 12'h020, 12'h030, 12'h040);
        wait_done("post_rst_done");
        chk("post_rst_busy", busy_cnt, 7);
        check_job(1, 2, 12'h020, 12'h030, 12'h040, 1, 2, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
